// File: rtl/wb_hash_initiator.sv
// wb_hash_initiator
//   Wishbone classic initiator that feeds one 512-bit block to the miner's slave port and
//   reads the digest back. A job runs as follows:
//     - write 16 block words, word 0 first (block_i[511:480]);
//     - read back 8 digest words (SHA-256) or 7 digest words (SHA-224);
//     - pulse done_o.
//   Every transfer is followed by one cycle with cyc/stb low, because the slave needs a
//   non-valid cycle between transfers. That also holds after the final read, so each word
//   costs exactly two cycles with a zero-wait slave.
//
// Ports
//   clk, reset_n           single clock, asynchronous active-low reset
//   start_i                job request, sampled only while idle
//   mode_i                 1 = SHA-256 (8 digest words), 0 = SHA-224 (7 words); latched at start
//   block_i                block to hash; latched at start
//   busy_o                 high from the accepted start until the DONE/ERR cycle
//   done_o                 one-cycle pulse when digest_o is valid
//   error_o                sticky ack-timeout flag, cleared by the next accepted start
//   digest_o               assembled digest (word 0 = [255:224]); held until the next start
//   wbm_*                  Wishbone classic initiator signals, all driven from registers
module wb_hash_initiator #(
  parameter int unsigned BITS           = 32,
  parameter logic [31:0] WB_BASE        = 32'h3000_0000,
  parameter int unsigned WR_WORDS       = 16,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start_i,
  input  logic            mode_i,
  input  logic [511:0]    block_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            error_o,
  output logic [255:0]    digest_o,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [3:0]      wbm_sel_o,
  output logic [31:0]     wbm_adr_o,
  output logic [BITS-1:0] wbm_dat_o,
  input  logic [BITS-1:0] wbm_dat_i,
  input  logic            wbm_ack_i
);

  localparam logic [3:0] WrLast  = 4'(WR_WORDS - 1);
  // Abort fires on the stalled cycle that would bring the counter to TIMEOUT_CYCLES.
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWrReq,
    StWrGap,
    StRdReq,
    StRdGap,
    StDone,
    StErr
  } state_e;

  state_e         state_q;
  logic [3:0]     idx_q;
  logic [7:0]     tmo_q;
  logic           mode_q;
  logic           last_q;     // final digest word captured, next gap ends the job
  logic [511:0]   blk_q;      // shifts left one word per write ack; top word is next to send
  logic           busy_q;
  logic           done_q;
  logic           error_q;
  logic [255:0]   digest_q;
  logic           cyc_q;
  logic           stb_q;
  logic           we_q;
  logic [3:0]     sel_q;
  logic [31:0]    adr_q;
  logic [31:0]    dat_q;

  logic [31:0]    idx_adr;
  logic           rd_is_last;
  logic           tmo_hit;
  logic [7:0]     dig_lsb;

  always_comb begin
    idx_adr    = WB_BASE + {26'd0, idx_q, 2'b00};
    rd_is_last = (idx_q[2:0] == (mode_q ? 3'd7 : 3'd6));
    tmo_hit    = (tmo_q == TmoLast);
    dig_lsb    = {3'd7 - idx_q[2:0], 5'd0};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      idx_q    <= '0;
      tmo_q    <= '0;
      mode_q   <= 1'b0;
      last_q   <= 1'b0;
      blk_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      digest_q <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      we_q     <= 1'b0;
      sel_q    <= '0;
      adr_q    <= '0;
      dat_q    <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            blk_q    <= block_i;
            mode_q   <= mode_i;
            error_q  <= 1'b0;
            digest_q <= '0;
            idx_q    <= '0;
            tmo_q    <= '0;
            last_q   <= 1'b0;
            busy_q   <= 1'b1;
            // First write goes out directly; no gap is needed after idle.
            cyc_q    <= 1'b1;
            stb_q    <= 1'b1;
            we_q     <= 1'b1;
            sel_q    <= 4'hF;
            adr_q    <= WB_BASE;
            dat_q    <= block_i[511:480];
            state_q  <= StWrReq;
          end
        end

        StWrReq: begin
          if (wbm_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            tmo_q <= '0;
            blk_q <= {blk_q[479:0], 32'h0};
            if (idx_q == WrLast) begin
              // Switch the bus to read shape during the gap.
              idx_q   <= '0;
              we_q    <= 1'b0;
              sel_q   <= 4'h0;
              dat_q   <= '0;
              state_q <= StRdGap;
            end else begin
              idx_q   <= idx_q + 4'd1;
              state_q <= StWrGap;
            end
          end else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            we_q    <= 1'b0;
            sel_q   <= 4'h0;
            tmo_q   <= '0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StErr;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        StWrGap: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          adr_q   <= idx_adr;
          dat_q   <= blk_q[511:480];
          state_q <= StWrReq;
        end

        StRdReq: begin
          if (wbm_ack_i) begin
            digest_q[dig_lsb +: 32] <= wbm_dat_i;
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            tmo_q <= '0;
            if (rd_is_last) begin
              last_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
            state_q <= StRdGap;
          end else if (tmo_hit) begin
            cyc_q   <= 1'b0;
            stb_q   <= 1'b0;
            tmo_q   <= '0;
            error_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StErr;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end

        StRdGap: begin
          if (last_q) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= StDone;
          end else begin
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            adr_q   <= idx_adr;
            state_q <= StRdReq;
          end
        end

        StDone: state_q <= StIdle;

        StErr: state_q <= StIdle;

        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign error_o   = error_q;
  assign digest_o  = digest_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule
